atom_npu_mac: RTL and testbench



---
 rtl/atom_npu_pkg.sv | 32 +++
 rtl/atom_npu_requant.sv | 47 ++++
 rtl/atom_npu_mac.sv | 102 ++++++++++
 tb/tb_atom_npu_mac.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/atom_npu_pkg.sv
// Shared types and helpers for the atom NPU dot-product core.
// The ATOM_NPU_RELU_EN macro is consumed by atom_npu_requant.
package atom_npu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESULT,
    DONE
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // The accumulator is sized so that LEN worst-case products can never overflow it.
  function automatic int acc_width(input int data_w, input int weight_w, input int len);
    return data_w + weight_w + clog2(len) + 1;
  endfunction

  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/atom_npu_requant.sv
// Combinational requantiser: arithmetic right shift, optional ReLU, signed saturation.
// Define ATOM_NPU_RELU_EN to clamp negative results to zero.
module atom_npu_requant
  import atom_npu_pkg::*;
#(
  parameter int ACC_W = 11,
  parameter int OUT_W = 8,
  parameter int SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [OUT_W-1:0] out_data,
  output logic                    out_sat
);

`ifdef ATOM_NPU_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  // One bit wider than either operand so the range compare is exact for any ACC_W/OUT_W pair.
  localparam int CMP_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam logic signed [CMP_W-1:0] MAX_V = CMP_W'(sat_max(OUT_W));
  localparam logic signed [CMP_W-1:0] MIN_V = CMP_W'(sat_min(OUT_W));

  logic signed [ACC_W-1:0] shifted;
  logic signed [CMP_W-1:0] s;

  assign shifted = acc >>> SHIFT;
  assign s       = CMP_W'(shifted);

  // NOTE: every output gets a default first so no path through the block can infer a latch.
  always_comb begin
    out_data = s[OUT_W-1:0];
    out_sat  = 1'b0;
    if (RELU && (s < 0)) begin
      out_data = '0;
    end else if (s > MAX_V) begin
      out_data = MAX_V[OUT_W-1:0];
      out_sat  = 1'b1;
    end else if (s < MIN_V) begin
      out_data = MIN_V[OUT_W-1:0];
      out_sat  = 1'b1;
    end
  end

endmodule

// File: rtl/atom_npu_mac.sv
// Streaming signed dot-product core with full-precision accumulation and requantised output.
// Optional ReLU in the requantiser is enabled by defining ATOM_NPU_RELU_EN.
module atom_npu_mac
  import atom_npu_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int WEIGHT_W = 4,
  parameter int LEN      = 4,
  parameter int OUT_W    = 8,
  parameter int SHIFT    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [WEIGHT_W-1:0] in_weight,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_sat,
  output logic                busy
);

  localparam int ACC_W = acc_width(DATA_W, WEIGHT_W, LEN);
  localparam int CNT_W = (LEN > 1) ? clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_t                  state, state_next;
  logic signed [ACC_W-1:0] acc, product;
  logic        [CNT_W-1:0] cnt;
  logic        [OUT_W-1:0] rq_data;
  logic                    rq_sat;
  logic                    beat;

  assign beat    = in_valid && in_ready;
  assign product = ACC_W'($signed(in_data)) * ACC_W'($signed(in_weight));

  atom_npu_requant #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .acc      (acc),
    .out_data (rq_data),
    .out_sat  (rq_sat)
  );

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM: begin
        in_ready = 1'b1;
        if (beat && (cnt == LAST)) state_next = RESULT;
      end
      RESULT:  state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: all datapath registers are plain flops and are reset; there is no memory array here.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc <= '0;
          cnt <= '0;
        end
        ACCUM: if (beat) begin
          acc <= acc + product;
          cnt <= cnt + 1'b1;
        end
        RESULT: begin
          out_data <= rq_data;
          out_sat  <= rq_sat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atom_npu_mac.sv
// Self-checking bench: SHIFT=0 and SHIFT=2 instances driven in lockstep against an arithmetic model.
// Honours ATOM_NPU_RELU_EN in the model when the RTL is built with it.
module tb_atom_npu_mac;

  localparam int LEN = 4;

`ifdef ATOM_NPU_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] in_data = '0;
  logic [3:0] in_weight = '0;

  logic       in_ready0, out_valid0, out_sat0, busy0;
  logic [7:0] out_data0;
  logic       in_ready2, out_valid2, out_sat2, busy2;
  logic [7:0] out_data2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d0;
    logic       s0;
    logic [7:0] d2;
    logic       s2;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_d0 = '0, last_d2 = '0;
  logic       last_s0 = 1'b0, last_s2 = 1'b0;
  bit         mon_en = 1'b0;

  always #5 clk = ~clk;

  atom_npu_mac #(.DATA_W(4), .WEIGHT_W(4), .LEN(LEN), .OUT_W(8), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_sat(out_sat0), .busy(busy0)
  );

  atom_npu_mac #(.DATA_W(4), .WEIGHT_W(4), .LEN(LEN), .OUT_W(8), .SHIFT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_sat(out_sat2), .busy(busy2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Dot product, arithmetic shift, optional ReLU, clamp to signed 8 bits.
  function automatic void model(input int d[4], input int w[4], input int sh,
                                output logic [7:0] od, output logic os);
    int s;
    s = 0;
    for (int i = 0; i < LEN; i++) s += d[i] * w[i];
    s  = s >>> sh;
    od = 8'(s);
    os = 1'b0;
    if (RELU && s < 0) begin
      od = 8'h00;
    end else if (s > 127) begin
      od = 8'h7F;
      os = 1'b1;
    end else if (s < -128) begin
      od = 8'h80;
      os = 1'b1;
    end
  endfunction

  // Compare process: every cycle, results must match the model while valid and hold afterwards.
  initial begin
    logic pre_hs, pre_rst;
    exp_t e;
    wait (mon_en);
    forever begin
      @(posedge clk);
      pre_hs  = out_valid0 && out_ready;
      pre_rst = rst;
      #1;
      if (pre_rst) begin
        exp_q.delete();
        last_d0 = '0; last_s0 = 1'b0; last_d2 = '0; last_s2 = 1'b0;
      end else if (pre_hs && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        last_d0 = e.d0; last_s0 = e.s0; last_d2 = e.d2; last_s2 = e.s2;
      end
      check("valid_lockstep", out_valid2, out_valid0);
      if (out_valid0) begin
        check("result_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("out_data_sh0", out_data0, exp_q[0].d0);
          check("out_sat_sh0", out_sat0, exp_q[0].s0);
          check("out_data_sh2", out_data2, exp_q[0].d2);
          check("out_sat_sh2", out_sat2, exp_q[0].s2);
        end
      end else begin
        check("hold_data_sh0", out_data0, last_d0);
        check("hold_sat_sh0", out_sat0, last_s0);
        check("hold_data_sh2", out_data2, last_d2);
        check("hold_sat_sh2", out_sat2, last_s2);
      end
    end
  end

  // stall_mode: 0 none, 1 alternate in_valid, 2 random gaps.
  task automatic run_dot(input int d[4], input int w[4], input int stall_mode, input bit spur,
                         input int hold, input bit start_at_hs, input bit lit,
                         input logic [7:0] l0, input logic l0s, input logic [7:0] l2);
    int   k, guard;
    exp_t e;
    logic [7:0] od;
    logic       os;
    @(negedge clk);
    check("idle_before_start", busy0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_in_accum", busy0, 1);
    k = 0;
    guard = 0;
    while (k < LEN && guard < 100) begin
      check("in_ready_accum", in_ready0, 1);
      if ((stall_mode == 1 && guard[0]) || (stall_mode == 2 && $urandom_range(0, 1) == 1)) begin
        in_valid  = 1'b0;
        in_data   = 4'($urandom);
        in_weight = 4'($urandom);
      end else begin
        in_valid  = 1'b1;
        in_data   = 4'(d[k]);
        in_weight = 4'(w[k]);
      end
      start = spur && ($urandom_range(0, 2) == 0);
      @(posedge clk);
      if (in_valid && in_ready0) begin
        k++;
        if (k == LEN) begin
          model(d, w, 0, od, os); e.d0 = od; e.s0 = os;
          model(d, w, 2, od, os); e.d2 = od; e.s2 = os;
          exp_q.push_back(e);
        end
      end
      @(negedge clk);
      guard++;
    end
    check("beats_accepted_in_budget", k, LEN);
    in_valid = 1'b0;
    start    = 1'b0;
    check("result_cycle_no_valid", out_valid0, 0);
    check("result_cycle_no_ready", in_ready0, 0);
    @(negedge clk);
    check("latency_valid_t2", out_valid0, 1);
    if (lit) begin
      check("literal_data_sh0", out_data0, l0);
      check("literal_sat_sh0", out_sat0, l0s);
      check("literal_data_sh2", out_data2, l2);
    end
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      @(negedge clk);
      check("valid_held", out_valid0, 1);
    end
    out_ready = 1'b1;
    start     = start_at_hs;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check("valid_drops_after_hs", out_valid0, 0);
    check("idle_after_hs", busy0, 0);
    if (start_at_hs) begin
      @(negedge clk);
      check("start_at_hs_ignored", busy0, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd[4], rw[4];
    repeat (3) @(negedge clk);
    check("rst_busy", busy0, 0);
    check("rst_out_valid", out_valid0, 0);
    check("rst_in_ready", in_ready0, 0);
    check("rst_out_data", out_data0, 0);
    check("rst_out_sat", out_sat0, 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    run_dot('{1, 2, 3, 4}, '{1, 1, 1, 1}, 0, 0, 0, 0, 1, 8'h0A, 1'b0, 8'h02);
    run_dot('{7, 7, 7, 7}, '{7, 7, 7, 7}, 0, 0, 0, 0, 1, 8'h7F, 1'b1, 8'h31);
    run_dot('{-8, -8, -8, -8}, '{7, 7, 7, 7}, 0, 0, 0, 0, 1,
            RELU ? 8'h00 : 8'h80, RELU ? 1'b0 : 1'b1, RELU ? 8'h00 : 8'hC8);
    run_dot('{-1, 0, 0, 0}, '{1, 1, 1, 1}, 0, 0, 0, 0, 1,
            RELU ? 8'h00 : 8'hFF, 1'b0, RELU ? 8'h00 : 8'hFF);
    run_dot('{1, 2, 3, 4}, '{1, 1, 1, 1}, 1, 1, 5, 1, 1, 8'h0A, 1'b0, 8'h02);

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < LEN; i++) begin
        rd[i] = $signed(4'($urandom));
        rw[i] = $signed(4'($urandom));
      end
      run_dot(rd, rw, 2, 1, $urandom_range(0, 3), $urandom_range(0, 1), 0, 8'h00, 1'b0, 8'h00);
    end

    // Abort after two beats; a fresh run must carry no residue.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 4'd5; in_weight = 4'd7;
    @(negedge clk);
    in_data = 4'd6; in_weight = 4'd3;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy0, 0);
    check("abort_out_valid", out_valid0, 0);
    check("abort_in_ready", in_ready0, 0);
    rst = 1'b0;
    run_dot('{1, 1, 1, 1}, '{2, 2, 2, 2}, 0, 0, 0, 0, 1, 8'h08, 1'b0, 8'h02);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
